multi_strand_driver: RTL and testbench
======================================

MULTI_STRAND_DRIVER -- requirements
Module: multi_strand_driver

Interface
REQ-001 Parameter NUM_CHANNELS, 4, strands driven in lockstep.
REQ-002 Parameter BITS_PER_PIXEL, 24, bits per pixel word (24 RGB or 32 RGBW).
REQ-003 Parameter STRAND_PARAM_WIDTH, 16, width of pixel index and length fields.
REQ-004 Parameters T0H 50, T1H 120, TBIT 250, TCLKDIV2 10, TLATCH 5000: WS2811 0-bit high, 1-bit high, total bit period, WS2801 half-clock, end-of-frame latch; all in clk cycles, 16-bit counter.
REQ-005 clk  in  1  single clock; reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ws2811_mode  in  1  1 = WS2811 self-clocked; 0 = WS2801 clock+data.
REQ-008 chan_enable  in  NUM_CHANNELS  per-channel enable.
REQ-009 strand_length  in  NUM_CHANNELS*STRAND_PARAM_WIDTH  pixels per channel, channel 0 in LSBs.
REQ-010 start_frame  in  1  starts a frame when sampled high in IDLE.
REQ-011 abort  in  1  terminates the current frame.
REQ-012 mem_addr  out  STRAND_PARAM_WIDTH  pixel index to pixel RAM.
REQ-013 mem_data  in  NUM_CHANNELS*BITS_PER_PIXEL  pixel words, valid one cycle after mem_addr.
REQ-014 busy  out  1  frame in progress, including latch.
REQ-015 done  out  1  one-cycle pulse at frame end.
REQ-016 strand_clk / strand_data  out  NUM_CHANNELS each  registered IOB outputs.

Function
REQ-017 States: IDLE, START, FETCH, WAIT, PHASE_A, PHASE_B, LATCH.
REQ-018 IDLE->START on start_frame; START latches frame_len = max strand_length over enabled channels, mem_addr=0; frame_len==0 -> LATCH directly.
REQ-019 FETCH drives mem_addr; WAIT absorbs 1-cycle RAM latency; mem_data captured into a pixel shift register at WAIT exit -> PHASE_A.
REQ-020 Bits sent MSB first (bit BITS_PER_PIXEL-1 first).
REQ-021 WS2811 PHASE_A: all active channels data=1; channel goes low at T0H (bit 0) or T1H (bit 1) cycles after bit start; PHASE_B holds low until TBIT cycles after bit start; strand_clk=0.
REQ-022 WS2801 PHASE_A: data=bit, clk=0 for TCLKDIV2 cycles; PHASE_B: data held, clk=1 for TCLKDIV2 cycles.
REQ-023 Channel is active for pixel i only if chan_enable=1 and i < its strand_length; inactive channels drive clk=0, data=0 throughout.
REQ-024 After last bit of pixel: mem_addr+1; if mem_addr+1 < frame_len -> FETCH, else -> LATCH.
REQ-025 LATCH: all outputs 0 for TLATCH cycles, then done=1 for one cycle, busy=0, -> IDLE.
REQ-026 busy rises the cycle after start_frame sampled, falls with done.
REQ-027 start_frame while busy ignored; strand_length/chan_enable sampled only in START and per-pixel activity check.
REQ-028 abort in any non-IDLE, non-LATCH state: outputs 0 next cycle, -> LATCH (full latch, then done); abort in LATCH/IDLE ignored.
REQ-029 Simultaneous start_frame and abort in IDLE: start wins, abort ignored.
REQ-030 mem_addr arithmetic is STRAND_PARAM_WIDTH-bit; strand_length = 2^W-1 supported without wrap.

Reset
REQ-031 rst sampled high: state IDLE, busy 0, done 0, mem_addr 0, strand_clk 0, strand_data 0, counters 0, frame counter 0.
REQ-032 rst mid-frame aborts immediately with no latch period and no done pulse.

Configuration
REQ-033 Macro MULTI_STRAND_FRAME_COUNT_EN defined: extra output frame_count, 32 bits, increments on each done pulse, wraps 0xFFFFFFFF->0; undefined: port absent, no counter logic.

Structure
REQ-034 Shared package holds state encoding, default timing constants and counter width constant.
REQ-035 One sub-module natural: strand_bit_encoder (per-channel bit -> data/clk waveform from shared phase counter), instantiated NUM_CHANNELS times.

Verification
REQ-036 WS2811, 1 channel, length 1, pixel 0x800000 -> first bit high 120 cycles, next 23 bits high 50 cycles, each bit 250 cycles, then 5000 low, done pulse.
REQ-037 WS2801, 2 channels, lengths 2 and 1 -> ch1 clk/data 0 during pixel 1; 48 clk rising edges on ch0, 24 on ch1, period 20 cycles.
REQ-038 chan_enable=0b0101, all lengths 3 -> channels 1 and 3 constant 0; mem_addr sequence 0,1,2.
REQ-039 abort asserted at bit 5 of pixel 0 -> outputs 0 next cycle, done exactly 5001 cycles later (TLATCH then pulse).
REQ-040 rst asserted mid-PHASE_A -> all outputs 0 next cycle, busy 0, no done; new start_frame accepted.
REQ-041 All lengths 0, start_frame -> no data toggles, done after 5000-cycle latch; with macro, frame_count 0->1.

Source files
------------

// File: rtl/multi_strand_driver_pkg.sv
// Shared definitions for the multi-strand LED driver: FSM encoding, counter width
// and default WS2811 / WS2801 timing in clock cycles.
package multi_strand_driver_pkg;

   localparam int unsigned CNT_W        = 16;
   localparam int unsigned DEF_T0H      = 50;
   localparam int unsigned DEF_T1H      = 120;
   localparam int unsigned DEF_TBIT     = 250;
   localparam int unsigned DEF_TCLKDIV2 = 10;
   localparam int unsigned DEF_TLATCH   = 5000;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StFetch,
      StWait,
      StPhaseA,
      StPhaseB,
      StLatch
   } state_e;

endpackage

// File: rtl/multi_strand_driver_strand_bit_encoder.sv
// Per-channel waveform generator: turns the current pixel bit and the shared
// bit-phase counter into strand data/clock levels (combinational).
module strand_bit_encoder
   import multi_strand_driver_pkg::*;
#(
   parameter int unsigned T0H = DEF_T0H,
   parameter int unsigned T1H = DEF_T1H
) (
   input  logic             ws2811_mode,
   input  logic             active,
   input  logic             bit_val,
   input  logic             phase_b,
   input  logic [CNT_W-1:0] cnt,
   output logic             strand_data,
   output logic             strand_clk
);

   always_comb begin
      strand_data = 1'b0;
      strand_clk  = 1'b0;
      if (active) begin
         if (ws2811_mode) begin
            // High from bit start until the bit-dependent high time elapses.
            strand_data = (cnt < (bit_val ? CNT_W'(T1H) : CNT_W'(T0H)));
         end else begin
            strand_data = bit_val;
            strand_clk  = phase_b;
         end
      end
   end

endmodule

// File: rtl/multi_strand_driver.sv
// Drives NUM_CHANNELS LED strands in lockstep (WS2811 self-clocked or WS2801 clock+data).
// Optional MULTI_STRAND_FRAME_COUNT_EN adds a 32-bit frame_count output.
module multi_strand_driver
   import multi_strand_driver_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS       = 4,
   parameter int unsigned BITS_PER_PIXEL     = 24,
   parameter int unsigned STRAND_PARAM_WIDTH = 16,
   parameter int unsigned T0H                = DEF_T0H,
   parameter int unsigned T1H                = DEF_T1H,
   parameter int unsigned TBIT               = DEF_TBIT,
   parameter int unsigned TCLKDIV2           = DEF_TCLKDIV2,
   parameter int unsigned TLATCH             = DEF_TLATCH
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         ws2811_mode,
   input  logic [NUM_CHANNELS-1:0]                      chan_enable,
   input  logic [NUM_CHANNELS*STRAND_PARAM_WIDTH-1:0]   strand_length,
   input  logic                                         start_frame,
   input  logic                                         abort,
   output logic [STRAND_PARAM_WIDTH-1:0]                mem_addr,
   input  logic [NUM_CHANNELS*BITS_PER_PIXEL-1:0]       mem_data,
   output logic                                         busy,
   output logic                                         done,
   output logic [NUM_CHANNELS-1:0]                      strand_clk,
   output logic [NUM_CHANNELS-1:0]                      strand_data
`ifdef MULTI_STRAND_FRAME_COUNT_EN
   ,
   output logic [31:0]                                  frame_count
`endif
);

   localparam int unsigned BIT_IDX_W = $clog2(BITS_PER_PIXEL);
   localparam int unsigned W         = STRAND_PARAM_WIDTH;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [BIT_IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic [W-1:0]              mem_addr_q, mem_addr_d, addr_next;
   logic [W-1:0]              frame_len_q, frame_len_d, max_len;
   logic [W-1:0]              lens [NUM_CHANNELS];
   logic [BITS_PER_PIXEL-1:0] pixel_q [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]   active_q, enc_data, enc_clk;
   logic [NUM_CHANNELS-1:0]   strand_clk_q, strand_data_q;
   logic                      busy_q, done_q, done_d;
   logic                      load_pixel, shift_pixel, out_en, in_phase_b;
   logic [CNT_W-1:0]          phase_a_end, bit_end;

   assign phase_a_end = ws2811_mode ? CNT_W'(T1H - 1) : CNT_W'(TCLKDIV2 - 1);
   assign bit_end     = ws2811_mode ? CNT_W'(TBIT - 1) : CNT_W'(2 * TCLKDIV2 - 1);
   assign addr_next   = mem_addr_q + W'(1);
   assign in_phase_b  = (state_q == StPhaseB);
   assign out_en      = ((state_q == StPhaseA) || in_phase_b) && !abort;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      assign lens[c] = strand_length[c*W +: W];

      strand_bit_encoder #(
         .T0H (T0H),
         .T1H (T1H)
      ) u_enc (
         .ws2811_mode (ws2811_mode),
         .active      (active_q[c]),
         .bit_val     (pixel_q[c][BITS_PER_PIXEL-1]),
         .phase_b     (in_phase_b),
         .cnt         (cnt_q),
         .strand_data (enc_data[c]),
         .strand_clk  (enc_clk[c])
      );
   end

   always_comb begin
      max_len = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (chan_enable[c] && (lens[c] > max_len)) max_len = lens[c];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      mem_addr_d  = mem_addr_q;
      frame_len_d = frame_len_q;
      load_pixel  = 1'b0;
      shift_pixel = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle:  if (start_frame) state_d = StStart;
         StStart: begin
            frame_len_d = max_len;
            mem_addr_d  = '0;
            cnt_d       = '0;
            state_d     = (max_len == '0) ? StLatch : StFetch;
         end
         StFetch: state_d = StWait;
         StWait: begin
            load_pixel = 1'b1;
            cnt_d      = '0;
            bit_idx_d  = '0;
            state_d    = StPhaseA;
         end
         StPhaseA: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == phase_a_end) state_d = StPhaseB;
         end
         StPhaseB: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == bit_end) begin
               cnt_d       = '0;
               shift_pixel = 1'b1;
               if (bit_idx_q == BIT_IDX_W'(BITS_PER_PIXEL - 1)) begin
                  bit_idx_d = '0;
                  if (addr_next < frame_len_q) begin
                     mem_addr_d = addr_next;
                     state_d    = StFetch;
                  end else begin
                     state_d = StLatch;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                  state_d   = StPhaseA;
               end
            end
         end
         StLatch: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TLATCH - 1)) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Abort still runs the full latch so the strands see a clean end of frame.
      if (abort && (state_q != StIdle) && (state_q != StLatch)) begin
         state_d     = StLatch;
         cnt_d       = '0;
         bit_idx_d   = '0;
         mem_addr_d  = mem_addr_q;
         load_pixel  = 1'b0;
         shift_pixel = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         mem_addr_q    <= '0;
         frame_len_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         strand_clk_q  <= '0;
         strand_data_q <= '0;
         active_q      <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) pixel_q[c] <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         mem_addr_q    <= mem_addr_d;
         frame_len_q   <= frame_len_d;
         busy_q        <= (state_d != StIdle);
         done_q        <= done_d;
         strand_data_q <= out_en ? enc_data : '0;
         strand_clk_q  <= out_en ? enc_clk : '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (load_pixel) begin
               pixel_q[c]  <= mem_data[c*BITS_PER_PIXEL +: BITS_PER_PIXEL];
               active_q[c] <= chan_enable[c] && (mem_addr_q < lens[c]);
            end else if (shift_pixel) begin
               pixel_q[c] <= {pixel_q[c][BITS_PER_PIXEL-2:0], 1'b0};
            end
         end
      end
   end

   assign mem_addr    = mem_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign strand_clk  = strand_clk_q;
   assign strand_data = strand_data_q;

`ifdef MULTI_STRAND_FRAME_COUNT_EN
   logic [31:0] frame_count_q;

   always_ff @(posedge clk) begin
      if (rst)         frame_count_q <= '0;
      else if (done_d) frame_count_q <= frame_count_q + 32'd1;
   end

   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_multi_strand_driver.sv
// Directed, table-driven bench for multi_strand_driver (default 4 x 24-bit configuration).
module tb_multi_strand_driver;

   localparam int NCH = 4;
   localparam int BPP = 24;
   localparam int W   = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               ws2811_mode;
   logic [NCH-1:0]     chan_enable;
   logic [NCH*W-1:0]   strand_length;
   logic               start_frame;
   logic               abort;
   logic [W-1:0]       mem_addr;
   logic [NCH*BPP-1:0] mem_data;
   logic               busy, done;
   logic [NCH-1:0]     strand_clk, strand_data;
`ifdef MULTI_STRAND_FRAME_COUNT_EN
   logic [31:0]        frame_count;
   int                 exp_fc = 0;
`endif

   multi_strand_driver dut (
      .clk           (clk),
      .rst           (rst),
      .ws2811_mode   (ws2811_mode),
      .chan_enable   (chan_enable),
      .strand_length (strand_length),
      .start_frame   (start_frame),
      .abort         (abort),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .busy          (busy),
      .done          (done),
      .strand_clk    (strand_clk),
`ifdef MULTI_STRAND_FRAME_COUNT_EN
      .frame_count   (frame_count),
`endif
      .strand_data   (strand_data)
   );

   always #5 clk = ~clk;

   // Registered pixel RAM: same pattern for every channel and address.
   logic [BPP-1:0] cur_pix = '0;
   always @(posedge clk) mem_data <= {NCH{cur_pix}};

   // Waveform monitor, sampled on the falling edge.
   logic     clr_mon = 1'b1;
   int       hi_c [NCH];
   int       rise_c [NCH];
   int       busy_c, done_c, run_len, first_run, t_cyc, t_r1, t_r2, last_addr;
   logic [NCH-1:0] prev_clk;

   always @(negedge clk) begin
      if (clr_mon) begin
         for (int c = 0; c < NCH; c++) begin
            hi_c[c]   <= 0;
            rise_c[c] <= 0;
         end
         busy_c <= 0; done_c <= 0; run_len <= 0; first_run <= 0;
         t_cyc <= 0; t_r1 <= -1; t_r2 <= -1;
         prev_clk <= strand_clk;
      end else begin
         t_cyc <= t_cyc + 1;
         for (int c = 0; c < NCH; c++) begin
            hi_c[c] <= hi_c[c] + int'(strand_data[c]);
            if (strand_clk[c] && !prev_clk[c]) rise_c[c] <= rise_c[c] + 1;
         end
         if (strand_clk[0] && !prev_clk[0]) begin
            if (t_r1 < 0)      t_r1 <= t_cyc;
            else if (t_r2 < 0) t_r2 <= t_cyc;
         end
         if (strand_data[0]) run_len <= run_len + 1;
         else begin
            if (run_len != 0 && first_run == 0) first_run <= run_len;
            run_len <= 0;
         end
         busy_c   <= busy_c + int'(busy);
         done_c   <= done_c + int'(done);
         prev_clk <= strand_clk;
      end
      last_addr <= int'(mem_addr);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk); #1 clr_mon = 1'b1;
      @(posedge clk); #1 clr_mon = 1'b0;
   endtask

   task automatic pulse_start(input logic with_abort);
      @(posedge clk); #1;
      start_frame = 1'b1;
      abort       = with_abort;
      @(posedge clk); #1;
      start_frame = 1'b0;
      abort       = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (!done && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   typedef struct packed {
      logic            ws;
      logic [3:0]      en;
      logic [3:0][15:0] len;
      logic [23:0]     pix;
      logic [3:0][15:0] hi;
      logic [3:0][7:0] rise;
      logic [15:0]     busy_len;
      logic [15:0]     addr;
      logic [15:0]     run;
      logic [15:0]     gap;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int n;
      rst = 1'b1; ws2811_mode = 1'b1; chan_enable = '0; strand_length = '0;
      start_frame = 1'b0; abort = 1'b0;

      // Busy cycles = 1 (START) + pixels*(2 + 24*bit_period) + 5000 (latch).
      tbl[0] = '{ws: 1'b1, en: 4'b0001, len: {16'd0, 16'd0, 16'd0, 16'd1}, pix: 24'h800000,
                 hi: {16'd0, 16'd0, 16'd0, 16'd1270}, rise: {8'd0, 8'd0, 8'd0, 8'd0},
                 busy_len: 16'd11003, addr: 16'd0, run: 16'd120, gap: 16'd0};
      tbl[1] = '{ws: 1'b0, en: 4'b0011, len: {16'd0, 16'd0, 16'd1, 16'd2}, pix: 24'hA5A5A5,
                 hi: {16'd0, 16'd0, 16'd240, 16'd480}, rise: {8'd0, 8'd0, 8'd24, 8'd48},
                 busy_len: 16'd5965, addr: 16'd1, run: 16'd20, gap: 16'd20};
      tbl[2] = '{ws: 1'b0, en: 4'b0101, len: {16'd3, 16'd3, 16'd3, 16'd3}, pix: 24'hFFFFFF,
                 hi: {16'd0, 16'd1440, 16'd0, 16'd1440}, rise: {8'd0, 8'd72, 8'd0, 8'd72},
                 busy_len: 16'd6447, addr: 16'd2, run: 16'd480, gap: 16'd20};
      tbl[3] = '{ws: 1'b0, en: 4'b0001, len: {16'd0, 16'd0, 16'd3, 16'd1}, pix: 24'h000001,
                 hi: {16'd0, 16'd0, 16'd0, 16'd20}, rise: {8'd0, 8'd0, 8'd0, 8'd24},
                 busy_len: 16'd5483, addr: 16'd0, run: 16'd20, gap: 16'd20};
      tbl[4] = '{ws: 1'b1, en: 4'b1111, len: '0, pix: 24'hFFFFFF,
                 hi: '0, rise: '0, busy_len: 16'd5001, addr: 16'd0, run: 16'd0, gap: 16'd0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_strand_clk", int'(strand_clk), 0);
      chk("rst_strand_data", int'(strand_data), 0);
`ifdef MULTI_STRAND_FRAME_COUNT_EN
      chk("rst_frame_count", int'(frame_count), 0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         ws2811_mode   = tbl[i].ws;
         chan_enable   = tbl[i].en;
         strand_length = tbl[i].len;
         cur_pix       = tbl[i].pix;
         clear_mon();
         pulse_start(1'b0);
         chk($sformatf("row%0d_busy_rise", i), int'(busy), 1);
         wait_done(30000, n);
         chk($sformatf("row%0d_done_seen", i), int'(done), 1);
         repeat (3) @(posedge clk);
         #1;
         for (int c = 0; c < NCH; c++) begin
            chk($sformatf("row%0d_hi%0d", i, c), hi_c[c], int'(tbl[i].hi[c]));
            chk($sformatf("row%0d_rise%0d", i, c), rise_c[c], int'(tbl[i].rise[c]));
         end
         chk($sformatf("row%0d_busy_cycles", i), busy_c, int'(tbl[i].busy_len));
         chk($sformatf("row%0d_done_cycles", i), done_c, 1);
         chk($sformatf("row%0d_last_addr", i), last_addr, int'(tbl[i].addr));
         chk($sformatf("row%0d_first_run", i), first_run, int'(tbl[i].run));
         chk($sformatf("row%0d_clk_period", i), (t_r2 >= 0) ? t_r2 - t_r1 : 0, int'(tbl[i].gap));
`ifdef MULTI_STRAND_FRAME_COUNT_EN
         exp_fc++;
         chk($sformatf("row%0d_frame_count", i), int'(frame_count), exp_fc);
`endif
      end

      // Abort in bit 5 of pixel 0; start_frame during the latch must be ignored.
      ws2811_mode = 1'b1; chan_enable = 4'b0001;
      strand_length = {16'd0, 16'd0, 16'd0, 16'd1}; cur_pix = 24'hFFFFFF;
      clear_mon();
      pulse_start(1'b0);
      repeat (1253 + 30) @(posedge clk);
      #1;
      chk("abort_pre_data", int'(strand_data[0]), 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_outputs_zero", int'({strand_data, strand_clk}), 0);
      chk("abort_busy_held", int'(busy), 1);
      n = 1;
      while (!done && n < 6000) begin
         start_frame = (n == 100);
         @(posedge clk); #1;
         n++;
      end
      start_frame = 1'b0;
      chk("abort_done_latency", n, 5001);
      @(posedge clk); #1;
      chk("abort_done_one_cycle", int'(done), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_busy_after", int'(busy), 0);
      chk("abort_done_count", done_c, 1);
`ifdef MULTI_STRAND_FRAME_COUNT_EN
      exp_fc++;
      chk("abort_frame_count", int'(frame_count), exp_fc);
`endif

      // Reset mid PHASE_A, then a simultaneous start+abort with zero lengths.
      clear_mon();
      pulse_start(1'b0);
      repeat (43) @(posedge clk);
      #1;
      chk("rstmid_pre_data", int'(strand_data[0]), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstmid_outputs_zero", int'({strand_data, strand_clk}), 0);
      chk("rstmid_busy", int'(busy), 0);
      repeat (300) @(posedge clk);
      #1;
      chk("rstmid_no_done", done_c, 0);
      chk("rstmid_mem_addr", int'(mem_addr), 0);
`ifdef MULTI_STRAND_FRAME_COUNT_EN
      exp_fc = 0;
`endif
      strand_length = '0; chan_enable = 4'b1111;
      clear_mon();
      pulse_start(1'b1);
      chk("start_abort_busy", int'(busy), 1);
      wait_done(8000, n);
      chk("start_abort_done_seen", int'(done), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("start_abort_busy_cycles", busy_c, 5001);
      chk("start_abort_hi0", hi_c[0], 0);
`ifdef MULTI_STRAND_FRAME_COUNT_EN
      exp_fc++;
      chk("start_abort_frame_count", int'(frame_count), exp_fc);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
